// File: rtl/arb_pkg.sv
// Shared encodings and sizing for the two-VC pop arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        RESET  = 2'b00,
        ACTIVE = 2'b01,
        PAUSE  = 2'b10
    } arb_state_e;

    localparam int ARB_VC0_BURST_MAX_DEF = 4;
    localparam int ARB_CNT_W             = 4;

endpackage

// File: rtl/arb_burst_counter.sv
// Saturating count of consecutive VC0 grants while VC1 waits; raises
// o_force_vc1 once the burst limit is reached and VC1 has data.
module arb_burst_counter
    import arb_pkg::*;
#(
    parameter int VC0_BURST_MAX = ARB_VC0_BURST_MAX_DEF
) (
    input  logic clk,
    input  logic reset_L,
    input  logic i_freeze,
    input  logic i_clear,
    input  logic i_incr,
    input  logic i_vc1_empty,
    output logic o_force_vc1
);

    localparam logic [ARB_CNT_W-1:0] MAX_C = ARB_CNT_W'(VC0_BURST_MAX);

    logic [ARB_CNT_W-1:0] r_cnt;

    // Freeze wins over clear so a paused arbiter keeps its fairness debt.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_cnt <= '0;
        end else if (!i_freeze) begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_incr && (r_cnt != MAX_C)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_force_vc1 = (r_cnt == MAX_C) && !i_vc1_empty;

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC pop arbiter with VC0 priority and delayed pop strobes for the mux.
// Optional fairness burst limit is compiled in with ARB_FAIRNESS_EN.
module vc_arbiter
    import arb_pkg::*;
#(
    parameter int VC0_BURST_MAX = ARB_VC0_BURST_MAX_DEF
) (
    input  logic clk,
    input  logic reset_L,
    input  logic vc0_empty,
    input  logic vc1_empty,
    input  logic d0_pause,
    input  logic d1_pause,
    output logic pop_vc0,
    output logic pop_vc1,
    output logic pop_delay_vc0,
    output logic pop_delay_vc1,
    output logic arb_paused
);

    if ((VC0_BURST_MAX < 1) || (VC0_BURST_MAX > 15)) begin : g_bad_burst_max
        $error("vc_arbiter: VC0_BURST_MAX must be in 1..15");
    end

    arb_state_e r_state;
    logic       r_pop_delay_vc0;
    logic       r_pop_delay_vc1;
    logic       r_arb_paused;

    logic w_pause;
    logic w_pop_en;
    logic w_force_vc1;
    logic w_pop_vc0;
    logic w_pop_vc1;

    assign w_pause  = d0_pause | d1_pause;
    // Current pause gates pops combinationally so none slips out the cycle it rises.
    assign w_pop_en = reset_L && (r_state == ACTIVE) && !w_pause;

    assign w_pop_vc0 = w_pop_en && !vc0_empty && !w_force_vc1;
    assign w_pop_vc1 = w_pop_en && !vc1_empty && !w_pop_vc0;

`ifdef ARB_FAIRNESS_EN
    arb_burst_counter #(
        .VC0_BURST_MAX (VC0_BURST_MAX)
    ) u_burst_counter (
        .clk         (clk),
        .reset_L     (reset_L),
        .i_freeze    (!w_pop_en),
        .i_clear     (w_pop_vc1 || vc1_empty),
        .i_incr      (w_pop_vc0),
        .i_vc1_empty (vc1_empty),
        .o_force_vc1 (w_force_vc1)
    );
`else
    assign w_force_vc1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state         <= RESET;
            r_pop_delay_vc0 <= 1'b0;
            r_pop_delay_vc1 <= 1'b0;
            r_arb_paused    <= 1'b0;
        end else begin
            r_pop_delay_vc0 <= w_pop_vc0;
            r_pop_delay_vc1 <= w_pop_vc1;
            case (r_state)
                RESET: begin
                    r_state      <= ACTIVE;
                    r_arb_paused <= 1'b0;
                end
                ACTIVE: begin
                    if (w_pause) begin
                        r_state      <= PAUSE;
                        r_arb_paused <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (!w_pause) begin
                        r_state      <= ACTIVE;
                        r_arb_paused <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= RESET;
                    r_arb_paused <= 1'b0;
                end
            endcase
        end
    end

    assign pop_vc0       = w_pop_vc0;
    assign pop_vc1       = w_pop_vc1;
    assign pop_delay_vc0 = r_pop_delay_vc0;
    assign pop_delay_vc1 = r_pop_delay_vc1;
    assign arb_paused    = r_arb_paused;

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_vc_arbiter;

    localparam int BMAX = 4;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    logic vc0_empty = 1'b1;
    logic vc1_empty = 1'b1;
    logic d0_pause = 1'b0;
    logic d1_pause = 1'b0;
    logic pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, arb_paused;

    vc_arbiter #(.VC0_BURST_MAX(BMAX)) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .vc0_empty     (vc0_empty),
        .vc1_empty     (vc1_empty),
        .d0_pause      (d0_pause),
        .d1_pause      (d1_pause),
        .pop_vc0       (pop_vc0),
        .pop_vc1       (pop_vc1),
        .pop_delay_vc0 (pop_delay_vc0),
        .pop_delay_vc1 (pop_delay_vc1),
        .arb_paused    (arb_paused)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;

    // Model: "live" = at least one edge seen out of reset; "paused" = arbiter sitting out.
    bit m_live = 0, m_paused = 0, m_prev0 = 0, m_prev1 = 0, m_en = 0;
    int m_cnt  = 0;
    bit e0, e1;
    logic [4:0] exp_v, obs_v;

    // Apply inputs, let them settle to mid-cycle, compute the expected outputs.
    task automatic drive(input bit r, input bit v0e, input bit v1e, input bit p0, input bit p1);
        bit frc;
        reset_L   = r;
        vc0_empty = v0e;
        vc1_empty = v1e;
        d0_pause  = p0;
        d1_pause  = p1;
        @(negedge clk);
        m_en = r && m_live && !m_paused && !(p0 || p1);
        frc  = 1'b0;
`ifdef ARB_FAIRNESS_EN
        frc = (m_cnt == BMAX) && !v1e;
`endif
        e0 = m_en && !v0e && !frc;
        e1 = m_en && !v1e && !e0;
        exp_v = {e0, e1, m_prev0, m_prev1, m_paused};
        obs_v = {pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, arb_paused};
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset_L) begin
            m_live = 0; m_paused = 0; m_prev0 = 0; m_prev1 = 0; m_cnt = 0;
        end else begin
            m_prev0 = e0;
            m_prev1 = e1;
            if (m_en) begin
                if (e1 || vc1_empty) m_cnt = 0;
                else if (e0 && m_cnt < BMAX) m_cnt = m_cnt + 1;
            end
            if (!m_live) m_live = 1;
            else m_paused = d0_pause || d1_pause;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
            vec++;
            if (obs_v !== exp_v) begin
                miss++;
                $display("FAIL reset cyc%0d: pop0,pop1,dly0,dly1,paused=%b want %b", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 0);
            vec++;
            if (obs_v !== exp_v) begin
                miss++;
                $display("FAIL idle cyc%0d: pop0,pop1,dly0,dly1,paused=%b want %b", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_vc0_stream();
        for (int i = 0; i < 7; i++) begin
            drive(1, (i >= 5), 1, 0, 0);
            vec++;
            if (obs_v !== exp_v) begin
                miss++;
                $display("FAIL vc0_stream cyc%0d: pop0,pop1,dly0,dly1,paused=%b want %b", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_priority();
        int n1 = 0;
        int want_n1;
`ifdef ARB_FAIRNESS_EN
        want_n1 = 2;
`else
        want_n1 = 0;
`endif
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0, 0);
            n1 += int'(pop_vc1);
            vec++;
            if (obs_v !== exp_v) begin
                miss++;
                $display("FAIL priority cyc%0d: pop0,pop1,dly0,dly1,paused=%b want %b", i, obs_v, exp_v);
            end
            advance();
        end
        vec++;
        if (n1 !== want_n1) begin
            miss++;
            $display("FAIL priority_vc1_count: got %0d want %0d", n1, want_n1);
        end
    endtask

    task automatic test_pause();
        for (int i = 1; i <= 9; i++) begin
            drive(1, 0, 1, 0, (i >= 3 && i <= 5));
            vec++;
            if (obs_v !== exp_v) begin
                miss++;
                $display("FAIL pause cyc%0d: pop0,pop1,dly0,dly1,paused=%b want %b", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 6; i++) begin
            drive((i != 2), 1, 0, 0, 0);
            vec++;
            if (obs_v !== exp_v) begin
                miss++;
                $display("FAIL midreset cyc%0d: pop0,pop1,dly0,dly1,paused=%b want %b", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 12; i++) begin
            drive(1, i[0], 0, 0, 0);
            vec++;
            if (obs_v !== exp_v) begin
                miss++;
                $display("FAIL toggle cyc%0d: pop0,pop1,dly0,dly1,paused=%b want %b", i, obs_v, exp_v);
            end
            vec++;
            if ((pop_vc0 + pop_vc1) !== 2'd1) begin
                miss++;
                $display("FAIL toggle_one_pop cyc%0d: pop0=%b pop1=%b want exactly one", i, pop_vc0, pop_vc1);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(39) != 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(7) == 0), ($urandom_range(7) == 0));
            vec++;
            if (obs_v !== exp_v) begin
                miss++;
                $display("FAIL random cyc%0d: pop0,pop1,dly0,dly1,paused=%b want %b", i, obs_v, exp_v);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_vc0_stream();
        test_priority();
        test_pause();
        test_midreset();
        test_toggle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
